uart_mmio: RTL
==============

// Module: uart_mmio
// PURPOSE
//  Memory-side peripheral/decoder directly downstream of the stack CPU data port.
//  Decodes mem_addr: 01h=UART DATA, 02h=UART STATUS, 20h-FFh passed to data RAM, others read 00h.
//  Contains 8N1 UART TX shifter, RX deserialiser and a small RX FIFO; returns rd_data to CPU.
// PARAMETERS
//  CLK_DIV   234  clock cycles per UART bit (>=4, even)
//  RX_DEPTH  4    RX FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  async active-low reset
//  mem_addr     in   8  CPU data address
//  mem_wr       in   1  1-cycle write strobe
//  mem_rd       in   1  1-cycle read-consume strobe (pops RX FIFO when addr=01h)
//  wr_data      in   8  CPU write data
//  rd_data      out  8  read data to CPU (combinational mux)
//  ram_wr       out  1  mem_wr & (mem_addr>=20h)
//  ram_rd_data  in   8  data RAM read data
//  uart_rx      in   1  serial input (async, idle high)
//  uart_tx      out  1  serial output (registered, idle high)
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: uart_tx=1, TX/RX FSMs IDLE, FIFO empty, all status flags 0; rd_data/ram_wr follow inputs.
//  rd_data: 01h -> FIFO head (00h if empty); 02h -> {4'b0,frame_err,overrun,tx_busy,rx_valid};
//   >=20h -> ram_rd_data; else 00h. Reads without mem_rd have no side effect.
//  STATUS read with mem_rd clears overrun and frame_err (after the data is returned).
//  TX write: mem_wr & addr=01h & TX IDLE -> latch byte, uart_tx=0 next cycle, tx_busy=1 same edge.
//   Write while tx_busy: ignored (byte dropped, no flag).
//  TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE; each state CLK_DIV cycles;
//   frame = 10*CLK_DIV cycles; tx_busy drops on the edge leaving STOP.
//  RX: uart_rx through 2-FF synchroniser; IDLE on falling edge -> START, wait CLK_DIV/2;
//   if line high -> IDLE (glitch, no flag); else sample 8 data bits every CLK_DIV (mid-bit),
//   then STOP sample: 1 -> push byte; 0 -> discard, frame_err=1; then IDLE.
//  FIFO: push when RX completes, pop on mem_rd & addr=01h & !empty; rx_valid = !empty.
//   Push while full: byte dropped, overrun=1 - unless a pop occurs same cycle (both proceed, no flag).
//   Pop while empty: no effect. Pointers wrap modulo RX_DEPTH; count width $clog2(RX_DEPTH)+1.
//  Counters: bit counter CLK_DIV-1..0, bit index 0..7; no overflow beyond terminal values.
//  Reset mid-frame: tx aborts immediately to 1, partial RX byte discarded, FIFO cleared.
// CONFIGURATION
//  UART_LOOPBACK_EN defined: RX synchroniser input = uart_tx (uart_rx ignored); for self-test.
//  Not defined: RX input = uart_rx. No other difference.
// TESTING (CLK_DIV=4, RX_DEPTH=4)
//  Write 01h<=A5h -> uart_tx low 1 cycle later; bits 1,0,1,0,0,1,0,1 then stop, 40 cycles; tx_busy 1->0.
//  Second write 01h<=3Ch during busy -> ignored; line carries only A5h frame.
//  Drive RX frame 5Ah -> STATUS=01h; read 01h with mem_rd -> 5Ah, STATUS=00h.
//  Drive 5 RX frames without reads -> STATUS=05h; reads return first 4 bytes in order; STATUS read clears.
//  RX frame with stop bit 0 -> FIFO unchanged, STATUS bit3=1; 1-cycle low glitch -> no change.
//  Write 40h<=77h -> ram_wr=1; write 10h -> ram_wr=0; read 00h/10h -> 00h. Loopback: write C3h -> read C3h.
//  Assert rst_n mid-TX-frame -> uart_tx=1 immediately, STATUS=00h.

Source files
------------

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped peripheral decoder sitting behind the stack CPU data port.
//   01h = UART DATA (write: transmit byte, read: RX FIFO head, mem_rd pops)
//   02h = UART STATUS {4'b0, frame_err, overrun, tx_busy, rx_valid} (mem_rd clears errors)
//   20h-FFh = data RAM pass-through, everything else reads 00h.
// Serial format is 8N1 at CLK_DIV clocks per bit.
// Build option: define UART_LOOPBACK_EN to feed the RX synchroniser from uart_tx
// instead of uart_rx (self-test loopback).
module uart_mmio #(
  parameter int CLK_DIV  = 234,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] mem_addr,
  input  logic       mem_wr,
  input  logic       mem_rd,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       ram_wr,
  input  logic [7:0] ram_rd_data,
  input  logic       uart_rx,
  output logic       uart_tx
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int PW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW:0]   FIFO_CAP = (PW + 1)'(RX_DEPTH);
  localparam logic [PW:0]   CNT1     = (PW + 1)'(1);
  localparam logic [PW-1:0] PTR1     = PW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Address decode
  logic sel_data, sel_stat, sel_ram;
  assign sel_data = (mem_addr == 8'h01);
  assign sel_stat = (mem_addr == 8'h02);
  assign sel_ram  = (mem_addr >= 8'h20);
  assign ram_wr   = mem_wr & sel_ram;

  // Status flags and FIFO state
  logic          tx_busy, overrun, frame_err;
  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full, rx_valid;
  logic          pop, push_ok, ovr_set, stat_clr;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_CAP);
  assign rx_valid   = ~fifo_empty;

  // Read-data mux back to the CPU
  always_comb begin
    rd_data = 8'h00;
    if (sel_ram)
      rd_data = ram_rd_data;
    else if (sel_data)
      rd_data = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    else if (sel_stat)
      rd_data = {4'b0000, frame_err, overrun, tx_busy, rx_valid};
  end

  // ---------------- TX ----------------
  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_shift;
  logic          tx_load, tx_adv;

  assign tx_load = mem_wr & sel_data & (tx_state == IDLE);
  assign tx_adv  = (tx_cnt == '0) & ((tx_state == START) | (tx_state == DATA));

  // TX frame sequencer; drives the registered serial line and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_busy  <= 1'b0;
      uart_tx  <= 1'b1;
    end else begin
      unique case (tx_state)
        IDLE: begin
          if (tx_load) begin
            tx_state <= START;
            tx_cnt   <= CNT_MAX;
            tx_busy  <= 1'b1;
            uart_tx  <= 1'b0;
          end
        end
        START: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end else begin
            tx_state <= DATA;
            tx_cnt   <= CNT_MAX;
            tx_idx   <= '0;
            uart_tx  <= tx_shift[0];
          end
        end
        DATA: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end else begin
            tx_cnt <= CNT_MAX;
            if (tx_idx == 3'd7) begin
              tx_state <= STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_idx  <= tx_idx + 3'd1;
              uart_tx <= tx_shift[0];
            end
          end
        end
        STOP: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end else begin
            tx_state <= IDLE;
            tx_busy  <= 1'b0;
          end
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  // TX shift register: next bit to send always sits in bit 0
  always_ff @(posedge clk) begin
    if (tx_load)
      tx_shift <= wr_data;
    else if (tx_adv)
      tx_shift <= {1'b0, tx_shift[7:1]};
  end

  // ---------------- RX ----------------
  logic rx_in;
`ifdef UART_LOOPBACK_EN
  logic rx_unused;
  assign rx_unused = uart_rx;
  assign rx_in     = uart_tx;
`else
  assign rx_in = uart_rx;
`endif

  logic          rx_sync_p0, rx_sync_p1, rx_prev;
  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_shift;
  logic          rx_push, rx_ferr, rx_sample;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
      rx_prev    <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_in;
      rx_sync_p1 <= rx_sync_p0;
      rx_prev    <= rx_sync_p1;
    end
  end

  assign rx_sample = (rx_state == DATA) & (rx_cnt == '0);

  // RX frame sequencer; samples mid-bit and emits one-cycle push / framing-error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_push  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      rx_ferr <= 1'b0;
      unique case (rx_state)
        IDLE: begin
          if (rx_prev & ~rx_sync_p1) begin
            rx_state <= START;
            rx_cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else if (rx_sync_p1) begin
            rx_state <= IDLE;          // start bit did not hold: line glitch
          end else begin
            rx_state <= DATA;
            rx_cnt   <= CNT_MAX;
            rx_idx   <= '0;
          end
        end
        DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else begin
            rx_cnt <= CNT_MAX;
            if (rx_idx == 3'd7)
              rx_state <= STOP;
            else
              rx_idx <= rx_idx + 3'd1;
          end
        end
        STOP: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - CNT_ONE;
          end else begin
            rx_state <= IDLE;
            if (rx_sync_p1)
              rx_push <= 1'b1;
            else
              rx_ferr <= 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // RX deserialiser: LSB arrives first, so shift in from the top
  always_ff @(posedge clk) begin
    if (rx_sample)
      rx_shift <= {rx_sync_p1, rx_shift[7:1]};
  end

  // ---------------- FIFO ----------------
  assign pop      = mem_rd & sel_data & ~fifo_empty;
  assign push_ok  = rx_push & (~fifo_full | pop);
  assign ovr_set  = rx_push & fifo_full & ~pop;
  assign stat_clr = mem_rd & sel_stat;

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR1;
      if (pop)     rd_ptr <= rd_ptr + PTR1;
      unique case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT1;
        2'b01:   fifo_cnt <= fifo_cnt - CNT1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage (data only, no reset needed: occupancy guards every read)
  always_ff @(posedge clk) begin
    if (push_ok)
      fifo_mem[wr_ptr] <= rx_shift;
  end

  // Sticky error flags: a new event in the clearing cycle is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (stat_clr) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (ovr_set) overrun   <= 1'b1;
      if (rx_ferr) frame_err <= 1'b1;
    end
  end

endmodule
